// File: rtl/johnson_ring_counter_pkg.sv
// Shared encodings and parameter rules for the Johnson/ring counter family.
package johnson_ring_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic logic width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/johnson_ring_counter_if.sv
// Control and status bundle of the Johnson/ring counter; clock and reset stay separate.
interface johnson_ring_counter_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned PW = $clog2(2 * WIDTH);

  logic             EN;
  logic             DIR;
  logic             MODE;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] Q;
  logic [PW-1:0]    PHASE;
  logic             ILLEGAL;
  logic             WRAP;

  modport master (
    output EN, DIR, MODE, LOAD, LOAD_VAL,
    input  Q, PHASE, ILLEGAL, WRAP
  );

  modport slave (
    input  EN, DIR, MODE, LOAD, LOAD_VAL,
    output Q, PHASE, ILLEGAL, WRAP
  );
endinterface

// File: rtl/johnson_ring_counter_phase_decode.sv
// Combinational legality check, phase index and next-state candidates for the counter ring.
module johnson_phase_decode
  import johnson_ring_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             illegal,
  output logic [PW-1:0]    phase,
  output logic [PW-1:0]    last_phase,
  output logic [WIDTH-1:0] next_down,
  output logic [WIDTH-1:0] next_up,
  output logic [WIDTH-1:0] seed
);

  logic             johnson;
  logic [WIDTH-2:0] trans;
  int unsigned      ones;
  int unsigned      ntrans;
  int unsigned      setidx;

  always_comb begin
    johnson = (mode == MODE_JOHNSON);
    trans   = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    ones    = 0;
    ntrans  = 0;
    setidx  = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        ones   = ones + 1;
        setidx = i;
      end
    end
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      if (trans[i]) ntrans = ntrans + 1;
    end

    // Johnson legality: at most one adjacent-bit change; ring: exactly one hot bit.
    illegal = johnson ? (ntrans > 1) : (ones != 1);

    if (illegal) begin
      phase = '0;
    end else if (johnson) begin
      phase = q[0] ? PW'(2 * WIDTH - ones) : PW'(ones);
    end else begin
      phase = PW'(WIDTH - 1 - setidx);
    end

    last_phase = johnson ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1);
    next_down  = {q[0] ^ johnson, q[WIDTH-1:1]};
    next_up    = {q[WIDTH-2:0], q[WIDTH-1] ^ johnson};
    seed       = johnson ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

endmodule

// File: rtl/johnson_ring_counter.sv
// Johnson / ring shift counter: state register, load/step/correct priority and wrap strobe.
module johnson_ring_counter
  import johnson_ring_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                   CLK,
  input logic                   RESET,
  johnson_ring_counter_if.slave bus
);

  localparam int unsigned PW = $clog2(2 * WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("johnson_ring_counter: WIDTH must be within 2..32");
  end

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             illegal;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    last_phase;
  logic [WIDTH-1:0] next_down;
  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] seed;

  johnson_phase_decode #(.WIDTH(WIDTH)) u_decode (
    .q          (q),
    .mode       (bus.MODE),
    .illegal    (illegal),
    .phase      (phase),
    .last_phase (last_phase),
    .next_down  (next_down),
    .next_up    (next_up),
    .seed       (seed)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (bus.LOAD) begin
      q    <= bus.LOAD_VAL;
      wrap <= 1'b0;
    end else if (bus.EN) begin
      if (illegal) begin
        q    <= seed;
        wrap <= 1'b0;
      end else if (bus.DIR == DIR_UP) begin
        q    <= next_up;
        wrap <= (phase == '0);
      end else begin
        q    <= next_down;
        wrap <= (phase == last_phase);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign bus.Q       = q;
  assign bus.WRAP    = wrap;
  assign bus.PHASE   = phase;
  assign bus.ILLEGAL = illegal;

endmodule

// File: doc/johnson_ring_counter.md
# johnson_ring_counter

Parametrised twisted-ring (Johnson) / ring shift counter. It is the general-width successor to the team's fixed 4-bit Johnson counter. It adds run-time selection of Johnson or ring mode and of shift direction, plus enable, parallel load, self-correction of illegal states, a binary phase index and a wrap pulse. It is used as a glitch-free multi-phase sequence source and timing-strobe generator.

## Interface
- WIDTH, 4, number of flip-flops in the ring; legal range 2–32.
- PW, $clog2(2*WIDTH), width of PHASE; derived, never overridden.

- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  step enable; one step per CLK edge while high.
- DIR  in  1  direction. 0 = shift toward LSB, Q[WIDTH-1] fed from the tail. 1 = shift toward MSB, Q[0] fed from the head.
- MODE  in  1  0 = Johnson (inverted feedback), 1 = ring (straight feedback).
- LOAD  in  1  synchronous parallel load of LOAD_VAL.
- LOAD_VAL  in  WIDTH  value written to Q on LOAD.
- Q  out  WIDTH  counter state, registered.
- PHASE  out  PW  phase index of Q in the current MODE; combinational from Q and MODE.
- ILLEGAL  out  1  Q is not a legal state for the current MODE; combinational.
- WRAP  out  1  registered one-cycle pulse on a boundary-crossing step.

## Operation
- Priority of actions: RESET > LOAD > EN. With none active, Q holds.
- Johnson step, DIR=0: Q <= {~Q[0], Q[WIDTH-1:1]}.
- Johnson step, DIR=1: Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]}.
- Ring step, DIR=0: Q <= {Q[0], Q[WIDTH-1:1]}.
- Ring step, DIR=1: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- Johnson legal states:
  - Q is 1s from the MSB down, then 0s; or 0s from the MSB down, then 1s.
  - Equivalently, at most one adjacent-bit change across Q[WIDTH-1:0].
  - This gives 2·WIDTH states.
- Ring legal states: exactly one bit set, giving WIDTH states.
- Self-correction:
  - If EN=1, LOAD=0 and ILLEGAL=1, the next Q is the mode seed instead of a step.
  - Johnson seed is all zeros. Ring seed is 1 in Q[WIDTH-1] only.
  - WRAP stays 0 on a correction.
- LOAD accepts any LOAD_VAL, including illegal values. ILLEGAL then asserts, and the next enabled cycle corrects the state.
- MODE or DIR changes take effect on the next step; no reset is needed.
  - A state legal in both modes (e.g. 1000) continues stepping.
  - An illegal state is corrected as above.
- PHASE, Johnson: p = popcount(Q). PHASE = p if Q[0]=0, else 2·WIDTH − p. The all-zero state is phase 0, and DIR=0 counts phase upward.
- PHASE, ring: PHASE = WIDTH−1−i, where i is the index of the set bit. The seed is phase 0.
- PHASE is 0 whenever ILLEGAL=1.
- Last phase is L = 2·WIDTH−1 in Johnson mode and WIDTH−1 in ring mode.
- WRAP is set on the edge where an enabled step moves:
  - from L to 0 with DIR=0, or
  - from 0 to L with DIR=1.
- WRAP is cleared on every other edge, including LOAD edges, correction edges and hold edges.

## Timing
- Reset values while RESET is high: Q = 0, WRAP = 0.
  - In Johnson mode this gives PHASE = 0 and ILLEGAL = 0.
  - In ring mode all-zero is illegal, so ILLEGAL = 1 and the first enabled edge loads the ring seed.
- RESET asserting mid-sequence clears Q and WRAP immediately, without waiting for a CLK edge. After RESET deasserts, the first CLK edge acts on EN and LOAD normally.
- Step latency: one edge. Q, WRAP and the updated PHASE are all visible after the edge on which EN=1.
- LOAD latency: one edge. LOAD with EN=1 on the same edge loads only and does not step.
- PHASE and ILLEGAL are purely combinational from Q and MODE; a MODE change updates them within the same cycle.
- Full Johnson period is 2·WIDTH enabled edges. Full ring period is WIDTH enabled edges.

## Structure
- Shared package `johnson_ring_pkg`:
  - MODE_JOHNSON = 1'b0, MODE_RING = 1'b1.
  - DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Parameter check rule: WIDTH in 2..32.
- Sub-module `johnson_phase_decode`, parameterised by WIDTH:
  - Inputs Q and MODE.
  - Outputs ILLEGAL and PHASE, purely combinational.
  - Also provides the next-state step values, so the top-level module contains only the register, priority mux and WRAP logic.

## Test plan
- WIDTH=4, MODE=0, DIR=0, EN=1 from reset, 9 edges → Q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000. PHASE = 1..7, 0, 1. WRAP is high only with the 0000 state.
- WIDTH=4, MODE=0, DIR=1 from 0000 → Q = 0001 (PHASE 7, WRAP=1), then 0011 (PHASE 6, WRAP=0).
- WIDTH=4, MODE=1 from reset → ILLEGAL=1 before the first edge. First edge gives 1000 (PHASE 0, WRAP=0), then 0100, 0010, 0001, 1000 (WRAP=1).
- LOAD with LOAD_VAL=0101, EN=1 on the same edge → Q = 0101, ILLEGAL=1, PHASE=0. Next enabled edge → Q = 0000 with MODE=0, or 1000 with MODE=1; WRAP=0 in both cases.
- WIDTH=4, MODE=0 at Q=1100, switch MODE to 1 → ILLEGAL=1 combinationally in the same cycle, next edge gives 1000. Then EN=0 for 3 edges → Q holds at 1000 and WRAP stays 0.
- WIDTH=4, RESET pulsed asynchronously mid-sequence at Q=1110 → Q = 0000 before the next CLK edge. Also run WIDTH=2 and WIDTH=7 full Johnson cycles, checking periods of 4 and 14 and WRAP once per period.
